// File: rtl/fgmt_pkg.sv
// rtl/fgmt_pkg.sv - shared types and constants for the multithreaded fetch path
//
// Purpose: instruction word/line/block types, the BUBBLE filler instruction,
// the refill FSM state encoding and a helper that unpacks an L2 line.
package fgmt_pkg;

  localparam int unsigned FGMT_WIDTH    = 32;
  localparam int unsigned FGMT_TID_BITS = 2;
  localparam int unsigned FGMT_WORDS    = 4;

  typedef logic [FGMT_TID_BITS-1:0]          tid_t;
  typedef logic [FGMT_WIDTH-1:0]             word_t;
  typedef logic [FGMT_WIDTH*FGMT_WORDS-1:0]  line_t;
  typedef word_t                             block_t [FGMT_WORDS];

  // Canonical no-op issued whenever no valid instruction is available.
  localparam word_t BUBBLE = 32'h0000_0013;

  typedef enum logic [2:0] {
    RS_IDLE  = 3'd0,
    RS_DREQ  = 3'd1,
    RS_DWAIT = 3'd2,
    RS_PREQ  = 3'd3,
    RS_PWAIT = 3'd4
  } refill_state_e;

  // Word 0 sits in the least significant bits of the line.
  function automatic block_t line_to_block(input line_t l);
    block_t b;
    for (int i = 0; i < int'(FGMT_WORDS); i++) begin
      b[i] = l[i*FGMT_WIDTH +: FGMT_WIDTH];
    end
    return b;
  endfunction

endpackage

// File: rtl/l1_icache_array.sv
// rtl/l1_icache_array.sv - direct-mapped tag/valid/data storage for the L1 icache
//
// Purpose: one combinational lookup port (hit + selected word), one
// combinational tag probe (hit only, used for next-line presence) and one
// synchronous line write port. A write to the looked-up index in the same
// cycle is forwarded to the lookup port.
// Ports:
//   clock, reset          clock, asynchronous active-low reset (valid bits only)
//   rd_idx_i/rd_tag_i     lookup index/tag
//   rd_sel_i              word select within the line
//   rd_hit_o/rd_word_o    lookup result
//   probe_idx_i/_tag_i    probe index/tag, probe_hit_o result
//   wr_en_i/wr_idx_i      line write strobe and index
//   wr_tag_i/wr_line_i    tag and line data written
module l1_icache_array
  import fgmt_pkg::*;
#(
  parameter  int unsigned NUM_LINES = 4,
  parameter  int unsigned TAG_BITS  = 26,
  localparam int unsigned IDX_BITS  = $clog2(NUM_LINES),
  localparam int unsigned SEL_BITS  = $clog2(FGMT_WORDS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  input  logic [TAG_BITS-1:0] rd_tag_i,
  input  logic [SEL_BITS-1:0] rd_sel_i,
  output logic                rd_hit_o,
  output word_t               rd_word_o,
  input  logic [IDX_BITS-1:0] probe_idx_i,
  input  logic [TAG_BITS-1:0] probe_tag_i,
  output logic                probe_hit_o,
  input  logic                wr_en_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0] wr_tag_i,
  input  line_t               wr_line_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  block_t               data_q [NUM_LINES];
  block_t               rd_blk;
  logic                 bypass;

  assign bypass = wr_en_i && (wr_idx_i == rd_idx_i);

  always_comb begin
    rd_blk   = data_q[rd_idx_i];
    rd_hit_o = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    if (bypass) begin
      rd_blk   = line_to_block(wr_line_i);
      rd_hit_o = (wr_tag_i == rd_tag_i);
    end
  end

  assign rd_word_o   = rd_blk[rd_sel_i];
  assign probe_hit_o = valid_q[probe_idx_i] && (tag_q[probe_idx_i] == probe_tag_i);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= line_to_block(wr_line_i);
    end
  end

endmodule

// File: rtl/l1_icache_mt.sv
// rtl/l1_icache_mt.sv - per-thread direct-mapped L1 instruction cache with next-line prefetch
//
// Purpose: zero-latency fetch hits for thread CTID, demand and next-line
// prefetch refills over a single-outstanding L2 request channel.
// Ports:
//   clock, reset                       clock, asynchronous active-low reset
//   tid_fetch, pc                      fetch slot owner and fetch address
//   br_valid, br_tid, br_target        branch redirect
//   l2_req_valid/ready/addr/tid/spec   refill request channel (spec=1 prefetch)
//   l2_rsp_valid/tid/addr/line         tagged L2 fill bus
//   instr_valid, instr, stall          fetch result (BUBBLE when not valid)
module l1_icache_mt
  import fgmt_pkg::*;
#(
  parameter int unsigned CTID           = 0,
  parameter int unsigned NUM_LINES      = 4,
  parameter int unsigned WORDS_PER_LINE = FGMT_WORDS,
  parameter int unsigned WIDTH          = FGMT_WIDTH,
  parameter int unsigned TID_BITS       = FGMT_TID_BITS,
  parameter int unsigned PREFETCH_EN    = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [TID_BITS-1:0]       tid_fetch,
  input  logic [WIDTH-1:0]          pc,
  input  logic                      br_valid,
  input  logic [TID_BITS-1:0]       br_tid,
  input  logic [WIDTH-1:0]          br_target,
  output logic                      l2_req_valid,
  input  logic                      l2_req_ready,
  output logic [WIDTH-1:0]          l2_req_addr,
  output logic [TID_BITS-1:0]       l2_req_tid,
  output logic                      l2_req_spec,
  input  logic                      l2_rsp_valid,
  input  logic [TID_BITS-1:0]       l2_rsp_tid,
  input  logic [WIDTH-1:0]          l2_rsp_addr,
  input  logic [WIDTH*WORDS_PER_LINE-1:0] l2_rsp_line,
  output logic                      instr_valid,
  output logic [WIDTH-1:0]          instr,
  output logic                      stall
);

  localparam int unsigned SEL_BITS = $clog2(WORDS_PER_LINE);
  localparam int unsigned OFF_BITS = SEL_BITS + 2;
  localparam int unsigned IDX_BITS = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS = WIDTH - OFF_BITS - IDX_BITS;
  localparam logic [TID_BITS-1:0] CTID_L = TID_BITS'(CTID);
  localparam logic [WIDTH-1:0] LINE_BYTES = WIDTH'(1) << OFF_BITS;

  refill_state_e    state_q;
  logic             req_valid_q, req_spec_q, pend_valid_q;
  logic [WIDTH-1:0] req_addr_q, pend_addr_q;

  logic             active, lookup, arr_hit, probe_hit, miss, pf_trigger;
  logic             waiting, fill_en;
  logic [WIDTH-1:0] lk_addr, lk_line, next_line;
  word_t            arr_word;
  logic             unused_bits;

  // The fetch slot owner wins; otherwise a redirect for this thread probes early.
  assign active  = (tid_fetch == CTID_L);
  assign lookup  = active || (br_valid && (br_tid == CTID_L));
  assign lk_addr = active ? pc : br_target;
  assign lk_line = {lk_addr[WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
  assign next_line = lk_line + LINE_BYTES;

  // req_addr_q keeps the outstanding line after the handshake.
  assign waiting = (state_q == RS_DWAIT) || (state_q == RS_PWAIT);
  assign fill_en = waiting && l2_rsp_valid && (l2_rsp_tid == CTID_L) &&
                   (l2_rsp_addr[WIDTH-1:OFF_BITS] == req_addr_q[WIDTH-1:OFF_BITS]);

  l1_icache_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .clock       (clock),
    .reset       (reset),
    .rd_idx_i    (lk_addr[OFF_BITS +: IDX_BITS]),
    .rd_tag_i    (lk_addr[WIDTH-1 -: TAG_BITS]),
    .rd_sel_i    (lk_addr[2 +: SEL_BITS]),
    .rd_hit_o    (arr_hit),
    .rd_word_o   (arr_word),
    .probe_idx_i (next_line[OFF_BITS +: IDX_BITS]),
    .probe_tag_i (next_line[WIDTH-1 -: TAG_BITS]),
    .probe_hit_o (probe_hit),
    .wr_en_i     (fill_en),
    .wr_idx_i    (req_addr_q[OFF_BITS +: IDX_BITS]),
    .wr_tag_i    (req_addr_q[WIDTH-1 -: TAG_BITS]),
    .wr_line_i   (l2_rsp_line)
  );

  assign miss       = lookup && !arr_hit;
  assign pf_trigger = (PREFETCH_EN != 0) && active && arr_hit &&
                      (&lk_addr[2 +: SEL_BITS]) && !probe_hit;

  // Gated by reset so the fetch outputs read idle while reset is held.
  assign instr_valid = reset && active && arr_hit;
  assign stall       = reset && active && !arr_hit;
  assign instr       = instr_valid ? arr_word : BUBBLE;

  assign l2_req_valid = req_valid_q;
  assign l2_req_addr  = req_addr_q;
  assign l2_req_spec  = req_spec_q;
  assign l2_req_tid   = CTID_L;

  assign unused_bits = ^{lk_addr[1:0], l2_rsp_addr[OFF_BITS-1:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= RS_IDLE;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_spec_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      unique case (state_q)
        RS_IDLE: begin
          if (miss) begin
            state_q     <= RS_DREQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= lk_line;
            req_spec_q  <= 1'b0;
          end else if (pf_trigger) begin
            state_q     <= RS_PREQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= next_line;
            req_spec_q  <= 1'b1;
          end
        end
        RS_DREQ, RS_PREQ: begin
          if (l2_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= (state_q == RS_DREQ) ? RS_DWAIT : RS_PWAIT;
          end
        end
        RS_DWAIT, RS_PWAIT: begin
          if (fill_en) begin
            // A lookup miss in the fill cycle already sees the bypassed line,
            // so it is necessarily for some other line.
            if (pend_valid_q) begin
              state_q      <= RS_DREQ;
              req_valid_q  <= 1'b1;
              req_addr_q   <= pend_addr_q;
              req_spec_q   <= 1'b0;
              pend_valid_q <= 1'b0;
            end else if (miss) begin
              state_q     <= RS_DREQ;
              req_valid_q <= 1'b1;
              req_addr_q  <= lk_line;
              req_spec_q  <= 1'b0;
            end else begin
              state_q <= RS_IDLE;
            end
          end else if (miss) begin
            if (lk_line == req_addr_q) begin
              state_q <= RS_DWAIT;
            end else begin
              pend_valid_q <= 1'b1;
              pend_addr_q  <= lk_line;
            end
          end
        end
        default: state_q <= RS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_icache_mt.sv
// tb/tb_l1_icache_mt.sv - self-checking bench for l1_icache_mt
module tb_l1_icache_mt;

  localparam logic [31:0] BUB = 32'h0000_0013;
  localparam logic [31:0] WA = 32'hA0A0_0001, WB = 32'hA0A0_0002,
                          WC = 32'hA0A0_0003, WD = 32'hA0A0_0004;

  logic         clock = 1'b0;
  logic         rst_n;
  logic [1:0]   tid_fetch, br_tid, l2_req_tid, l2_rsp_tid;
  logic [31:0]  pc, br_target, l2_req_addr, l2_rsp_addr, instr;
  logic         br_valid, l2_req_valid, l2_req_ready, l2_req_spec;
  logic         l2_rsp_valid, instr_valid, stall;
  logic [127:0] l2_rsp_line;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] addr; logic spec; } req_t;
  req_t exp_q[$];

  typedef struct {
    logic [1:0] tid; logic [31:0] pc; logic br_v; logic [1:0] br_t; logic [31:0] br_a;
    logic exp_v; logic [31:0] exp_i; logic exp_st;
  } vec_t;
  vec_t vecs[8];

  always #5 clock = ~clock;

  l1_icache_mt dut (
    .clock(clock), .reset(rst_n), .tid_fetch(tid_fetch), .pc(pc),
    .br_valid(br_valid), .br_tid(br_tid), .br_target(br_target),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_addr(l2_req_addr),
    .l2_req_tid(l2_req_tid), .l2_req_spec(l2_req_spec),
    .l2_rsp_valid(l2_rsp_valid), .l2_rsp_tid(l2_rsp_tid), .l2_rsp_addr(l2_rsp_addr),
    .l2_rsp_line(l2_rsp_line), .instr_valid(instr_valid), .instr(instr), .stall(stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic handshake();
    adv();
    l2_req_ready = 1'b1;
    @(negedge clock);
    adv();
    l2_req_ready = 1'b0;
  endtask

  function automatic logic [127:0] mk_line(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  // Request scoreboard: every accepted request must match the oldest expectation.
  always @(negedge clock) begin
    if (rst_n && l2_req_valid && l2_req_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected: got addr %h spec %0d expected none", l2_req_addr, l2_req_spec);
      end else begin
        req_t e;
        e = exp_q.pop_front();
        chk("req_addr", l2_req_addr, e.addr);
        chk("req_spec", 32'(l2_req_spec), 32'(e.spec));
        chk("req_tid", 32'(l2_req_tid), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'd0, 32'h100, 1'b0, 2'd0, 32'h0,   1'b1, WA,  1'b0};
    vecs[1] = '{2'd0, 32'h104, 1'b0, 2'd0, 32'h0,   1'b1, WB,  1'b0};
    vecs[2] = '{2'd0, 32'h108, 1'b0, 2'd0, 32'h0,   1'b1, WC,  1'b0};
    vecs[3] = '{2'd1, 32'h100, 1'b0, 2'd0, 32'h0,   1'b0, BUB, 1'b0};
    vecs[4] = '{2'd3, 32'h108, 1'b0, 2'd0, 32'h0,   1'b0, BUB, 1'b0};
    vecs[5] = '{2'd2, 32'h200, 1'b1, 2'd1, 32'h300, 1'b0, BUB, 1'b0};
    vecs[6] = '{2'd1, 32'h200, 1'b1, 2'd0, 32'h104, 1'b0, BUB, 1'b0};
    vecs[7] = '{2'd0, 32'h104, 1'b1, 2'd0, 32'h300, 1'b1, WB,  1'b0};

    rst_n = 1'b0; tid_fetch = 2'd0; pc = 32'h100; br_valid = 1'b0; br_tid = 2'd0;
    br_target = 32'h0; l2_req_ready = 1'b0; l2_rsp_valid = 1'b0; l2_rsp_tid = 2'd0;
    l2_rsp_addr = 32'h0; l2_rsp_line = '0;
    adv(); adv();
    @(negedge clock);
    chk("rst_req_valid", 32'(l2_req_valid), 32'd0);
    chk("rst_req_addr", l2_req_addr, 32'h0);
    chk("rst_req_spec", 32'(l2_req_spec), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, BUB);
    chk("rst_stall", 32'(stall), 32'd0);

    // Cold miss at 0x100 with the request held off for three cycles.
    adv();
    rst_n = 1'b1;
    exp_q.push_back('{32'h100, 1'b0});
    @(negedge clock);
    chk("cold_stall", 32'(stall), 32'd1);
    chk("cold_instr", instr, BUB);
    chk("cold_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      adv();
      @(negedge clock);
      chk("cold_req_valid", 32'(l2_req_valid), 32'd1);
      chk("cold_req_addr", l2_req_addr, 32'h100);
      chk("cold_req_spec", 32'(l2_req_spec), 32'd0);
      chk("cold_stall_hold", 32'(stall), 32'd1);
    end
    handshake();
    @(negedge clock);
    chk("cold_req_dropped", 32'(l2_req_valid), 32'd0);
    adv();
    l2_rsp_valid = 1'b1; l2_rsp_tid = 2'd0; l2_rsp_addr = 32'h100; l2_rsp_line = {WD, WC, WB, WA};
    @(negedge clock);
    chk("fill_bypass_instr", instr, WA);
    chk("fill_bypass_valid", 32'(instr_valid), 32'd1);
    adv();
    l2_rsp_valid = 1'b0;
    @(negedge clock);
    chk("cold_hit_instr", instr, WA);
    chk("cold_hit_valid", 32'(instr_valid), 32'd1);
    chk("cold_hit_stall", 32'(stall), 32'd0);

    // Table of single-cycle lookups that must not start any refill.
    for (int i = 0; i < 8; i++) begin
      adv();
      tid_fetch = vecs[i].tid; pc = vecs[i].pc; br_valid = vecs[i].br_v;
      br_tid = vecs[i].br_t; br_target = vecs[i].br_a;
      @(negedge clock);
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_v));
      chk($sformatf("vec%0d_instr", i), instr, vecs[i].exp_i);
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_st));
    end
    adv();
    br_valid = 1'b0; tid_fetch = 2'd1;
    @(negedge clock);
    chk("table_no_req", 32'(l2_req_valid), 32'd0);

    // Last word hit triggers a prefetch of 0x110.
    adv();
    tid_fetch = 2'd0; pc = 32'h10C;
    exp_q.push_back('{32'h110, 1'b1});
    @(negedge clock);
    chk("last_word_instr", instr, WD);
    adv();
    tid_fetch = 2'd1;
    @(negedge clock);
    chk("pf_req_valid", 32'(l2_req_valid), 32'd1);
    chk("pf_req_addr", l2_req_addr, 32'h110);
    chk("pf_req_spec", 32'(l2_req_spec), 32'd1);
    handshake();

    // Demand miss to the line being prefetched is promoted.
    tid_fetch = 2'd0; pc = 32'h110;
    @(negedge clock);
    chk("promote_stall", 32'(stall), 32'd1);
    chk("promote_instr", instr, BUB);
    for (int i = 0; i < 2; i++) begin
      adv();
      @(negedge clock);
      chk("promote_no_req", 32'(l2_req_valid), 32'd0);
      chk("promote_stall_hold", 32'(stall), 32'd1);
    end
    adv();
    l2_rsp_valid = 1'b1; l2_rsp_addr = 32'h110; l2_rsp_line = mk_line(32'hE000_0000);
    @(negedge clock);
    chk("promote_fill_instr", instr, 32'hE000_0000);
    adv();
    l2_rsp_valid = 1'b0;
    @(negedge clock);
    chk("promote_hit_instr", instr, 32'hE000_0000);
    chk("promote_hit_stall", 32'(stall), 32'd0);
    chk("promote_idle", 32'(l2_req_valid), 32'd0);

    // Miss to another line while a prefetch of 0x120 is outstanding.
    adv();
    pc = 32'h11C;
    exp_q.push_back('{32'h120, 1'b1});
    @(negedge clock);
    chk("last_word2_instr", instr, 32'hE000_0003);
    adv();
    tid_fetch = 2'd1;
    @(negedge clock);
    chk("pf2_req_addr", l2_req_addr, 32'h120);
    chk("pf2_req_spec", 32'(l2_req_spec), 32'd1);
    handshake();
    tid_fetch = 2'd0; pc = 32'h200;
    @(negedge clock);
    chk("pend_stall", 32'(stall), 32'd1);
    adv();
    exp_q.push_back('{32'h200, 1'b0});
    @(negedge clock);
    chk("pend_no_req", 32'(l2_req_valid), 32'd0);
    adv();
    l2_rsp_valid = 1'b1; l2_rsp_addr = 32'h120; l2_rsp_line = mk_line(32'hF000_0000);
    @(negedge clock);
    chk("pend_fill_stall", 32'(stall), 32'd1);
    chk("pend_fill_no_req", 32'(l2_req_valid), 32'd0);
    adv();
    l2_rsp_valid = 1'b0;
    @(negedge clock);
    chk("pend_req_valid", 32'(l2_req_valid), 32'd1);
    chk("pend_req_addr", l2_req_addr, 32'h200);
    chk("pend_req_spec", 32'(l2_req_spec), 32'd0);
    adv();
    pc = 32'h124;
    @(negedge clock);
    chk("pf_line_written", instr, 32'hF000_0001);
    chk("pend_req_stable", l2_req_addr, 32'h200);
    adv();
    pc = 32'h200;
    handshake();

    // Responses for another thread or another line are ignored.
    l2_rsp_valid = 1'b1; l2_rsp_tid = 2'd1; l2_rsp_addr = 32'h200; l2_rsp_line = mk_line(32'h2000_0000);
    @(negedge clock);
    chk("filter_tid_stall", 32'(stall), 32'd1);
    adv();
    l2_rsp_tid = 2'd0; l2_rsp_addr = 32'h300;
    @(negedge clock);
    chk("filter_addr_stall", 32'(stall), 32'd1);
    adv();
    l2_rsp_valid = 1'b0;
    @(negedge clock);
    chk("filter_still_stall", 32'(stall), 32'd1);
    adv();
    l2_rsp_valid = 1'b1; l2_rsp_addr = 32'h200;
    @(negedge clock);
    chk("filter_fill_instr", instr, 32'h2000_0000);
    chk("filter_fill_stall", 32'(stall), 32'd0);
    adv();
    l2_rsp_valid = 1'b0;
    @(negedge clock);
    chk("filter_hit_valid", 32'(instr_valid), 32'd1);

    // Redirect miss starts a request; reset drops it immediately.
    adv();
    tid_fetch = 2'd1; br_valid = 1'b1; br_tid = 2'd0; br_target = 32'h104;
    @(negedge clock);
    chk("redir_instr", instr, BUB);
    chk("redir_stall", 32'(stall), 32'd0);
    adv();
    br_valid = 1'b0;
    @(negedge clock);
    chk("redir_req_valid", 32'(l2_req_valid), 32'd1);
    chk("redir_req_addr", l2_req_addr, 32'h100);
    #2;
    rst_n = 1'b0; tid_fetch = 2'd0; pc = 32'h110;
    #1;
    chk("mid_rst_req_valid", 32'(l2_req_valid), 32'd0);
    chk("mid_rst_req_addr", l2_req_addr, 32'h0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_instr", instr, BUB);
    adv(); adv();
    rst_n = 1'b1; tid_fetch = 2'd1;
    l2_rsp_valid = 1'b1; l2_rsp_tid = 2'd0; l2_rsp_addr = 32'h110; l2_rsp_line = mk_line(32'h5000_0000);
    @(negedge clock);
    chk("stray_rsp_no_req", 32'(l2_req_valid), 32'd0);
    adv();
    l2_rsp_valid = 1'b0; tid_fetch = 2'd0; pc = 32'h110;
    exp_q.push_back('{32'h110, 1'b0});
    @(negedge clock);
    chk("post_rst_stall", 32'(stall), 32'd1);
    chk("post_rst_valid", 32'(instr_valid), 32'd0);
    adv();
    @(negedge clock);
    chk("post_rst_req_valid", 32'(l2_req_valid), 32'd1);
    chk("post_rst_req_addr", l2_req_addr, 32'h110);
    handshake();
    l2_rsp_valid = 1'b1; l2_rsp_addr = 32'h110; l2_rsp_line = mk_line(32'h6000_0000);
    @(negedge clock);
    chk("post_rst_fill", instr, 32'h6000_0000);
    adv();
    l2_rsp_valid = 1'b0;
    @(negedge clock);
    chk("post_rst_hit", instr, 32'h6000_0000);
    chk("post_rst_nostall", 32'(stall), 32'd0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL req_queue_drained: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
